clk_period_meter: RTL and testbench

//   Receive-side companion to the divided-clock generators. Samples a slow

---
 rtl/clk_period_meter.sv | 174 +++++++++++++++++
 tb/tb_clk_period_meter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures a slow clock (or tick) that is asynchronous to clk. The slow
//   input is synchronized, its rising edges are detected, and the clk-cycle
//   distance between consecutive rising edges (period) and the number of
//   high cycles inside that period (high_time) are reported with a
//   one-cycle valid pulse. locked shows that two consecutive periods agree
//   within TOL cycles. lost flags that no rising edge arrived for TIMEOUT
//   cycles. lost is sticky until the next rising edge.
//
// Ports
//   clk        in   1      system clock, all logic on posedge
//   rst_n      in   1      asynchronous active-low reset
//   clk_in     in   1      slow clock under measurement (asynchronous)
//   period     out  CNT_W  clk cycles between the last two clk_in rises
//   high_time  out  CNT_W  clk cycles clk_in was high within that period
//   valid      out  1      one-cycle pulse when period/high_time update
//   locked     out  1      consecutive periods agree within TOL
//   lost       out  1      no rising edge for TIMEOUT cycles
//
// Keep TIMEOUT < 2**CNT_W; otherwise the counter saturates first and the
// timeout can never fire.
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 32000,
  parameter int TOL         = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  // A TIMEOUT beyond the counter range is unreachable; compare is disabled.
  localparam bit TO_REACHABLE = (64'(TIMEOUT) < (64'(1) << CNT_W));

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    TRACK
  } state_t;

  // Saturating increment shared by both counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // |a - b| <= TOL, evaluated in signed arithmetic one bit wider than CNT_W.
  function automatic logic within_tol(input logic [CNT_W-1:0] a,
                                      input logic [CNT_W-1:0] b);
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    if (diff < 0) diff = -diff;
    return (diff <= $signed((CNT_W+1)'(TOL)));
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d_q;
  logic                   rise;
  logic                   rise_q;
  logic                   s_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hcnt_q, hcnt_d;
  logic                   timeout;
  state_t                 state_q;
  logic [CNT_W-1:0]       period_q;
  logic [CNT_W-1:0]       high_q;
  logic                   valid_q;
  logic                   locked_q;
  logic                   lost_q;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  // Synchronizer, edge detect, then one register stage on the edge/level
  // pair so the counters and FSM work from a clean registered event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      rise_q <= 1'b0;
      s_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      s_d_q  <= s;
      rise_q <= rise;
      s_q    <= s;
    end
  end

  // cnt restarts at 1 on a rise so it equals the period on the next rise;
  // hcnt restarts at 0 and counts the high cycles following the rise cycle.
  always_comb begin
    cnt_d  = rise_q ? CNT_W'(1) : sat_inc(cnt_q);
    hcnt_d = hcnt_q;
    if (rise_q)   hcnt_d = '0;
    else if (s_q) hcnt_d = sat_inc(hcnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  // A rise on the timeout cycle wins, so timeout is only looked at when
  // rise_q is low.
  assign timeout = TO_REACHABLE && (cnt_q == TO_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The first rise only starts a measurement and clears lost.
          if (rise_q) begin
            lost_q  <= 1'b0;
            state_q <= FIRST;
          end
        end
        FIRST: begin
          if (rise_q) begin
            period_q <= cnt_q;
            high_q   <= hcnt_q;
            valid_q  <= 1'b1;
            state_q  <= TRACK;
          end else if (timeout) begin
            lost_q   <= 1'b1;
            locked_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        TRACK: begin
          if (rise_q) begin
            period_q <= cnt_q;
            high_q   <= hcnt_q;
            valid_q  <= 1'b1;
            locked_q <= within_tol(cnt_q, period_q);
          end else if (timeout) begin
            lost_q   <= 1'b1;
            locked_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter: directed clk_in waveforms; every expected
// valid report is queued when its rise is driven and checked by a separate
// monitor when the DUT pulses valid.
module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int SS    = 2;
  localparam int T     = 10050;
  localparam int TOL   = 2;

  logic             clk;
  logic             rst_n;
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             lost;

  clk_period_meter #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(SS),
    .TIMEOUT(T),
    .TOL(TOL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_in(clk_in),
    .period(period),
    .high_time(high_time),
    .valid(valid),
    .locked(locked),
    .lost(lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int per;
    int hi;
    int lk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per valid pulse.
  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        n_total++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=1 expected no report (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("valid_cycle", cyc, mon_e.cyc);
        chk("period", int'(period), mon_e.per);
        chk("high_time", int'(high_time), mon_e.hi);
        chk("locked", int'(locked), mon_e.lk);
        chk("lost_at_valid", int'(lost), 0);
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      mon_e = sb.pop_front();
      n_total++;
      n_fail++;
      $display("FAIL missing_valid: got none by cycle %0d expected at cycle %0d", cyc, mon_e.cyc);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clk_in period starting with a rise at the current negedge. When ev
  // is set, the rise is expected to report (ep, eh, el) describing the
  // period that this rise closes.
  task automatic send(input int hi, input int lo, input bit ev,
                      input int ep, input int eh, input int el);
    clk_in = 1'b1;
    if (ev) sb.push_back('{cyc + SS + 2, ep, eh, el});
    hold(hi);
    clk_in = 1'b0;
    hold(lo);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high_time"}, int'(high_time), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_lost"}, int'(lost), 0);
  endtask

  int k;

  initial begin
    rst_n  = 1'b0;
    clk_in = 1'b0;
    // Reset held while clk_in toggles: nothing may report.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      clk_in = ~clk_in;
    end
    chk_outputs_zero("reset");
    clk_in = 1'b0;
    hold(1);
    rst_n = 1'b1;
    hold(5);

    // Steady 5001/5001: 10002-cycle period, 5000 high cycles after the
    // rise cycle. Locks from the second report.
    send(5001, 5001, 0, 0, 0, 0);
    send(5001, 5001, 1, 10002, 5000, 0);
    send(5001, 5001, 1, 10002, 5000, 1);
    send(5001, 5003, 1, 10002, 5000, 1);
    // Tolerance: +2 keeps lock, +6 drops it, an equal period re-locks.
    send(5001, 5009, 1, 10004, 5000, 1);
    send(5001, 5009, 1, 10010, 5000, 0);

    // Last rise, then clk_in held low until lost fires.
    k = cyc;
    clk_in = 1'b1;
    sb.push_back('{k + SS + 2, 10010, 5000, 1});
    hold(5001);
    clk_in = 1'b0;
    while (cyc < k + SS + 1 + T) @(negedge clk);
    chk("lost_before_timeout", int'(lost), 0);
    chk("locked_before_timeout", int'(locked), 1);
    hold(1);
    chk("lost_at_timeout", int'(lost), 1);
    chk("locked_at_timeout", int'(locked), 0);
    chk("period_hold_on_loss", int'(period), 10010);
    chk("high_hold_on_loss", int'(high_time), 5000);
    hold(20);
    chk("lost_sticky", int'(lost), 1);

    // Resume: lost clears on the first rise, which does not report.
    k = cyc;
    clk_in = 1'b1;
    hold(SS + 1);
    chk("lost_until_rise", int'(lost), 1);
    hold(1);
    chk("lost_cleared", int'(lost), 0);
    hold(100 - SS - 2);
    clk_in = 1'b0;
    hold(100);
    // Second rise reports; the next rise lands exactly on cnt == TIMEOUT.
    send(1, T - 1, 1, 200, 99, 0);
    send(1, 49, 1, T, 0, 0);
    chk("lost_after_boundary_rise", int'(lost), 0);
    // Single-cycle high pulses: high_time 0.
    send(1, 49, 1, 50, 0, 0);
    send(20, 20, 1, 50, 0, 1);

    // Reset during a high phase clears outputs without waiting for clk.
    clk_in = 1'b1;
    sb.push_back('{cyc + SS + 2, 40, 19, 0});
    hold(10);
    chk("period_before_reset", int'(period), 40);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    clk_in = 1'b0;
    hold(3);
    rst_n = 1'b1;
    hold(5);
    // First post-reset rise is an IDLE rise; the second reports.
    send(20, 20, 0, 0, 0, 0);
    send(20, 20, 1, 40, 19, 0);
    hold(10);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
